// File: rtl/booth_multiplier_8bits_pkg.sv
// Shared definitions for the Booth multiplier stage: FSM encoding, iteration count and the
// start/finish handshake used by this stage and the upstream complement-conversion stage.
package booth_multiplier_8bits_pkg;

  // FSM state encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned MULT_ITER = 8;

  // Booth recoding of {q[0], q_m1}; the other two codes leave the accumulator unchanged.
  localparam logic [1:0] BoothAdd = 2'b01;
  localparam logic [1:0] BoothSub = 2'b10;

  // Handshake: the sequencer raises `sel` for exactly one cycle to start an operation; the
  // stage raises `finish` as a level that stays up until the next `sel` or reset.
  localparam int unsigned HS_SEL_PULSE_CYCLES = 1;

  typedef struct packed {
    logic sel;
    logic finish;
  } stage_hs_t;

endpackage

// File: rtl/booth_addsub.sv
// Combinational accumulator update for one Booth step: add, subtract or pass the multiplicand
// according to the recoded pair {q[0], q_m1}.
module booth_addsub
  import booth_multiplier_8bits_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] mcand,
  input  logic [1:0]     sel,
  output logic [WIDTH:0] acc_next
);

  always_comb begin
    acc_next = acc;
    unique case (sel)
      BoothAdd: acc_next = acc + mcand;
      BoothSub: acc_next = acc - mcand;
      default:  acc_next = acc;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_8bits.sv
// Sequential radix-2 Booth multiplier: one recoded add/subtract plus arithmetic shift per cycle,
// producing a registered 2*WIDTH-bit signed product after WIDTH iterations.
module booth_multiplier_8bits
  import booth_multiplier_8bits_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_finish,
  output logic               busy
);

  localparam logic [3:0] LastIter = 4'(MULT_ITER - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [WIDTH:0]     mcand_q, mcand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               finish_q, finish_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     acc_sum;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   q_sh;

  booth_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .sel      ({q_q[0], q_m1_q}),
    .acc_next (acc_sum)
  );

  // Arithmetic right shift of {acc', q, q_m1}; the sign bit of acc' is replicated.
  assign acc_sh = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
  assign q_sh   = {acc_sum[0], q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    finish_d  = finish_q;
    busy_d    = busy_q;

    if (mult_sel) begin
      // A start pulse reloads from any state, including mid-run.
      mcand_d   = {a[WIDTH-1], a};
      q_d       = b;
      acc_d     = '0;
      q_m1_d    = 1'b0;
      cnt_d     = '0;
      product_d = '0;
      finish_d  = 1'b0;
      busy_d    = 1'b1;
      state_d   = StRun;
    end else begin
      unique case (state_q)
        StIdle: begin
          finish_d = 1'b0;
        end
        StRun: begin
          acc_d  = acc_sh;
          q_d    = q_sh;
          q_m1_d = q_q[0];
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LastIter) begin
            product_d = {acc_sh[WIDTH-1:0], q_sh};
            finish_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = StDone;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d  = StIdle;
          finish_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q_m1_q    <= q_m1_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
    end
  end

  assign product     = product_q;
  assign mult_finish = finish_q;
  assign busy        = busy_q;

endmodule
